unpacked_serializer: RTL and testbench
======================================

Name: unpacked_serializer

Overview:
- Width-down converter for unpacked-array streams.
- Accepts one beat of IN_NUM elements on a valid/ready interface and emits it as RATIO = IN_NUM/OUT_NUM consecutive beats of OUT_NUM elements.
- Sits downstream of wide unpacked buffers and feeds narrower compute lanes.
- Single holding register; sustains full output throughput (back-to-back input beats with no bubble).

Parameters:
- DATA_WIDTH, 8, bit width of one element.
- IN_NUM, 8, elements per input beat.
- OUT_NUM, 2, elements per output beat. IN_NUM % OUT_NUM must be 0; elaboration error otherwise.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- data_in  input  DATA_WIDTH x [IN_NUM-1:0] unpacked  wide input beat.
- data_in_valid  input  1  input beat valid.
- data_in_ready  output  1  block can accept an input beat.
- data_out  output  DATA_WIDTH x [OUT_NUM-1:0] unpacked  narrow output beat.
- data_out_valid  output  1  output beat valid.
- data_out_ready  input  1  downstream accepts the output beat.
- data_out_last  output  1  high on the final chunk of a wide beat.

Behaviour:
- Constants: RATIO = IN_NUM/OUT_NUM; CNT_W = max(1, clog2(RATIO)).
- State: hold[IN_NUM] elements, hold_valid (1b), cnt (CNT_W).
- Reset (async, rst=1): hold_valid=0, cnt=0, hold all zero. Outputs: data_out_valid=0, data_out=0, data_out_last=0 if RATIO>1, otherwise 1; data_in_ready=1.
- Two states, encoded by hold_valid:
  - EMPTY: hold_valid=0.
  - BUSY: hold_valid=1.
- Output decode (combinational from registers):
  - data_out[j] = hold[cnt*OUT_NUM + j] for j = 0..OUT_NUM-1; lowest element indices go out first.
  - data_out_valid = hold_valid.
  - data_out_last = (cnt == RATIO-1).
- Output handshake: out_fire = data_out_valid & data_out_ready.
- data_in_ready = !hold_valid | (out_fire & data_out_last). This combinational ready path from data_out_ready is intentional, to get zero-bubble back-to-back operation.
- Input handshake: in_fire = data_in_valid & data_in_ready.
- Per cycle, priority order:
  1. in_fire: hold <= data_in, hold_valid <= 1, cnt <= 0. This covers EMPTY, and BUSY on its last chunk being consumed in the same cycle.
  2. Else out_fire & data_out_last: hold_valid <= 0, cnt <= 0.
  3. Else out_fire: cnt <= cnt + 1.
  4. Else hold state.
- Latency: input accepted at edge N → first chunk valid in cycle N+1. Wide-beat throughput is 1 per RATIO cycles under continuous ready.
- Stall: data_out_ready=0 keeps data_out and data_out_last stable while valid (AXI-stream rule). valid never drops without a fire.
- data_in must not be sampled except on in_fire; values while !data_in_valid are don't-care.
- RATIO==1: degenerates to a full-throughput one-entry register slice; data_out_last is tied 1.
- Reset asserted mid-beat: remaining chunks are discarded; outputs return to reset values immediately (async); first post-reset in_fire restarts at cnt=0.
- cnt never exceeds RATIO-1. Wrap occurs only through rule 1 or 2.

Decomposition:
- No package-level types needed beyond the common one; RATIO and CNT_W are localparams.
- One natural sub-module: unpacked_chunk_select (combinational, parameters DATA_WIDTH/IN_NUM/OUT_NUM, ports in[IN_NUM], sel[CNT_W], out[OUT_NUM]). It is reusable by the matching deserializer/packer.
- Top level holds the registers and handshake logic; target 120-200 lines total.

Test Plan:
- Reset: rst=1 asynchronously mid-cycle → data_out_valid=0 and data_in_ready=1 before the next edge; data_out all 0.
- Single beat, IN_NUM=8, OUT_NUM=2, data_in={7,6,5,4,3,2,1,0} (index 7..0), ready=1 → chunks {1,0},{3,2},{5,4},{7,6} on cycles N+1..N+4; data_out_last only on the 4th; data_in_ready=1 on cycle N+4.
- Back-to-back: continuous valid with beats A (elements 0..7) and B (elements 10..17), ready=1 → 8 consecutive valid output cycles, no bubble; B accepted in the same cycle A's last chunk fires.
- Backpressure: data_out_ready toggles 1,0,0,1,... → each chunk held stable while ready=0; data_in_ready stays 0 until the last chunk fires; total 4 fires per beat, no duplication or loss.
- Reset mid-beat: rst pulse after 2 of 4 chunks → valid drops; next beat C emits from its chunk 0 ({C1,C0}).
- Degenerate RATIO=1 (IN_NUM=OUT_NUM=4) with randomized valid/ready over 1000 beats → output stream equals input stream in order; data_out_last constantly 1; scoreboard reports no mismatch.

Source files
------------

// File: rtl/unpacked_serializer_pkg.sv
// rtl/unpacked_serializer_pkg.sv - shared types and sizing helper for the unpacked serializer
package unpacked_serializer_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    BUSY  = 1'b1
  } hold_state_t;

  // Chunk counter width; a single-chunk ratio still needs a 1-bit counter.
  function automatic int cnt_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/unpacked_chunk_select.sv
// rtl/unpacked_chunk_select.sv - picks chunk sel (OUT_NUM elements) out of an IN_NUM-element array
module unpacked_chunk_select
  import unpacked_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IN_NUM     = 8,
  parameter int OUT_NUM    = 2,
  localparam int CNT_W     = cnt_width(IN_NUM / OUT_NUM)
) (
  input  logic [DATA_WIDTH-1:0] in  [IN_NUM-1:0],
  input  logic [CNT_W-1:0]      sel,
  output logic [DATA_WIDTH-1:0] out [OUT_NUM-1:0]
);

  // Explicit compare-mux keeps out-of-range sel values at zero instead of indexing past the array.
  always_comb begin
    for (int j = 0; j < OUT_NUM; j++) begin
      out[j] = '0;
      for (int i = 0; i < IN_NUM; i++) begin
        if (i == int'(sel) * OUT_NUM + j) begin
          out[j] = in[i];
        end
      end
    end
  end

endmodule

// File: rtl/unpacked_serializer.sv
// rtl/unpacked_serializer.sv - splits one IN_NUM-element beat into IN_NUM/OUT_NUM narrow beats
module unpacked_serializer
  import unpacked_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IN_NUM     = 8,
  parameter int OUT_NUM    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in [IN_NUM-1:0],
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out [OUT_NUM-1:0],
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  data_out_last
);

  localparam int RATIO = IN_NUM / OUT_NUM;
  localparam int CNT_W = cnt_width(RATIO);

  if (OUT_NUM < 1 || (IN_NUM % OUT_NUM) != 0) begin : g_bad_ratio
    $error("unpacked_serializer: IN_NUM must be a positive multiple of OUT_NUM");
  end

  hold_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] hold [IN_NUM-1:0];
  logic                  load;
  logic                  out_fire;
  logic                  in_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      cnt_q   <= '0;
      hold    <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        hold <= data_in;
      end
    end
  end

  assign data_out_valid = (state_q == BUSY);
  assign data_out_last  = (cnt_q == CNT_W'(RATIO - 1));

  // Ready looks through to data_out_ready so the next wide beat lands as the last chunk leaves.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    load          = 1'b0;
    out_fire      = data_out_valid & data_out_ready;
    data_in_ready = (state_q == EMPTY) | (out_fire & data_out_last);
    in_fire       = data_in_valid & data_in_ready;
    if (in_fire) begin
      state_d = BUSY;
      cnt_d   = '0;
      load    = 1'b1;
    end else if (out_fire && data_out_last) begin
      state_d = EMPTY;
      cnt_d   = '0;
    end else if (out_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  unpacked_chunk_select #(
    .DATA_WIDTH(DATA_WIDTH),
    .IN_NUM    (IN_NUM),
    .OUT_NUM   (OUT_NUM)
  ) u_chunk_select (
    .in (hold),
    .sel(cnt_q),
    .out(data_out)
  );

endmodule

// File: tb/tb_unpacked_serializer.sv
// tb/tb_unpacked_serializer.sv - randomized model-checked bench for 8:2 and 4:4 serializer configs
module tb_unpacked_serializer;

  logic       clk = 1'b0;
  logic       rst;
  int         n_checks = 0;
  int         n_errors = 0;

  // Config A: 8 elements in, 2 out (4 chunks per beat)
  logic [7:0] a_in [7:0];
  logic       a_vld, a_in_ready;
  logic [7:0] a_out [1:0];
  logic       a_out_valid, a_ordy, a_last;
  logic [15:0] qa[$];

  // Config B: 4 in, 4 out (register slice)
  logic [7:0] b_in [3:0];
  logic       b_vld, b_in_ready;
  logic [7:0] b_out [3:0];
  logic       b_out_valid, b_ordy, b_last;
  logic [31:0] qb[$];
  int          b_acc = 0;

  always #5 clk = ~clk;

  unpacked_serializer #(.DATA_WIDTH(8), .IN_NUM(8), .OUT_NUM(2)) dut_a (
    .clk(clk), .rst(rst),
    .data_in(a_in), .data_in_valid(a_vld), .data_in_ready(a_in_ready),
    .data_out(a_out), .data_out_valid(a_out_valid), .data_out_ready(a_ordy),
    .data_out_last(a_last)
  );

  unpacked_serializer #(.DATA_WIDTH(8), .IN_NUM(4), .OUT_NUM(4)) dut_b (
    .clk(clk), .rst(rst),
    .data_in(b_in), .data_in_valid(b_vld), .data_in_ready(b_in_ready),
    .data_out(b_out), .data_out_valid(b_out_valid), .data_out_ready(b_ordy),
    .data_out_last(b_last)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of config A; model is a queue of outstanding chunks, lowest elements first.
  task automatic cycle_a(input bit vld, input bit rdy, input logic [63:0] beat);
    bit exp_rdy;
    for (int i = 0; i < 8; i++) a_in[i] = beat[8*i +: 8];
    a_vld  = vld;
    a_ordy = rdy;
    #1;
    exp_rdy = (qa.size() == 0) || (qa.size() == 1 && rdy);
    chk("a_out_valid", a_out_valid, qa.size() != 0);
    chk("a_in_ready", a_in_ready, exp_rdy);
    if (qa.size() != 0) begin
      chk("a_data", {a_out[1], a_out[0]}, qa[0]);
      chk("a_last", a_last, qa.size() == 1);
      if (rdy) void'(qa.pop_front());
    end
    if (vld && exp_rdy)
      for (int k = 0; k < 4; k++) qa.push_back(beat[16*k +: 16]);
    @(posedge clk);
    #1;
  endtask

  task automatic cycle_b(input bit vld, input bit rdy, input logic [31:0] beat);
    bit exp_rdy;
    for (int i = 0; i < 4; i++) b_in[i] = beat[8*i +: 8];
    b_vld  = vld;
    b_ordy = rdy;
    #1;
    exp_rdy = (qb.size() == 0) || rdy;
    chk("b_out_valid", b_out_valid, qb.size() != 0);
    chk("b_in_ready", b_in_ready, exp_rdy);
    chk("b_last", b_last, 1'b1);
    if (qb.size() != 0) begin
      chk("b_data", {b_out[3], b_out[2], b_out[1], b_out[0]}, qb[0]);
      if (rdy) void'(qb.pop_front());
    end
    if (vld && exp_rdy) begin
      qb.push_back(beat);
      b_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    logic [63:0] beat_a, beat_b, beat_c;
    bit          pat [4];
    int          cyc;
    logic [31:0] bb;

    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b1;
    a_vld = 1'b0; a_ordy = 1'b0; b_vld = 1'b0; b_ordy = 1'b0;
    for (int i = 0; i < 8; i++) a_in[i] = '0;
    for (int i = 0; i < 4; i++) b_in[i] = '0;
    #2;
    chk("rst_a_valid", a_out_valid, 1'b0);
    chk("rst_a_ready", a_in_ready, 1'b1);
    chk("rst_a_last", a_last, 1'b0);
    chk("rst_a_data", {a_out[1], a_out[0]}, 16'h0);
    chk("rst_b_last", b_last, 1'b1);
    chk("rst_b_valid", b_out_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single beat, elements 0..7
    cycle_a(1'b1, 1'b1, 64'h0706050403020100);
    chk("single_chunk0", {a_out[1], a_out[0]}, 16'h0100);
    for (int k = 0; k < 4; k++) cycle_a(1'b0, 1'b1, 64'h0);

    // Back-to-back: B held valid until it is taken with A's last chunk
    beat_a = 64'h0706050403020100;
    beat_b = 64'h11100f0e0d0c0b0a;
    cycle_a(1'b1, 1'b1, beat_a);
    for (int k = 0; k < 4; k++) cycle_a(1'b1, 1'b1, beat_b);
    for (int k = 0; k < 4; k++) cycle_a(1'b0, 1'b1, 64'h0);

    // Backpressure: ready 1,0,0,1 repeating, two beats queued at the input
    cyc = 0;
    for (int n = 0; n < 2; n++) begin
      beat_a = rnd64();
      while (!(qa.size() == 0 || (qa.size() == 1 && pat[cyc % 4])) && cyc < 100) begin
        cycle_a(1'b1, pat[cyc % 4], beat_a);
        cyc++;
      end
      cycle_a(1'b1, pat[cyc % 4], beat_a);
      cyc++;
    end
    while (qa.size() != 0 && cyc < 200) begin
      cycle_a(1'b0, pat[cyc % 4], 64'h0);
      cyc++;
    end
    chk("bp_drained", qa.size(), 0);

    // Reset mid-beat after two chunks, then beat C restarts at chunk 0
    cycle_a(1'b1, 1'b1, rnd64());
    cycle_a(1'b0, 1'b1, 64'h0);
    cycle_a(1'b0, 1'b1, 64'h0);
    a_vld = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_valid", a_out_valid, 1'b0);
    chk("midrst_ready", a_in_ready, 1'b1);
    chk("midrst_data", {a_out[1], a_out[0]}, 16'h0);
    chk("midrst_last", a_last, 1'b0);
    qa.delete();
    qb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    beat_c = 64'hc7c6c5c4c3c2c1c0;
    cycle_a(1'b1, 1'b1, beat_c);
    chk("post_rst_c0", {a_out[1], a_out[0]}, 16'hc1c0);
    for (int k = 0; k < 4; k++) cycle_a(1'b0, 1'b1, 64'h0);

    // Randomized traffic on config A
    for (int k = 0; k < 400; k++)
      cycle_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), rnd64());
    while (qa.size() != 0 && cyc < 400) begin
      cycle_a(1'b0, 1'b1, 64'h0);
      cyc++;
    end
    a_vld = 1'b0;

    // Randomized traffic on the RATIO=1 config, 1000 accepted beats
    cyc = 0;
    while (b_acc < 1000 && cyc < 20000) begin
      bb = $urandom();
      cycle_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), bb);
      cyc++;
    end
    chk("b_accepted", b_acc, 1000);
    cyc = 0;
    while (qb.size() != 0 && cyc < 10) begin
      cycle_b(1'b0, 1'b1, 32'h0);
      cyc++;
    end
    chk("b_drained", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
